// File: rtl/ysyx_23060096_mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU and LSU.
// One outstanding transaction; responses are registered back to the owner.
module ysyx_23060096_mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rsp_err,
    output logic                busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IFU,
        OWN_LSU
    } owner_t;

    state_t        state;
    state_t        state_n;
    owner_t        owner;
    logic          rr_lsu;
    logic [CW-1:0] cnt;
    logic          grant_ifu;
    logic          grant_lsu;
    logic          rsp_fire;
    logic          tmo_fire;
    logic          done;
    logic [DATA_W-1:0] rsp_data;
    logic          rsp_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        rsp_fire  = 1'b0;
        tmo_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                // rr_lsu=1 means the LSU wins a tie
                if (ifu_req_valid && (!lsu_req_valid || !rr_lsu)) begin
                    grant_ifu = 1'b1;
                end else if (lsu_req_valid) begin
                    grant_lsu = 1'b1;
                end
                if (grant_ifu || grant_lsu) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_fire = 1'b1;
                    state_n  = IDLE;
                end else if (TMO_EN && cnt == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);
    assign done          = rsp_fire || tmo_fire;
    assign rsp_data      = tmo_fire ? '0 : mem_rdata;
    assign rsp_err       = tmo_fire ? 1'b1 : mem_rsp_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner         <= OWN_NONE;
            rr_lsu        <= 1'b0;
            cnt           <= '0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rdata     <= '0;
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rdata     <= '0;
            lsu_rsp_err   <= 1'b0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            if (grant_ifu) begin
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '0;
                owner     <= OWN_IFU;
                rr_lsu    <= 1'b1;
            end
            if (grant_lsu) begin
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
                owner     <= OWN_LSU;
                rr_lsu    <= 1'b0;
            end
            if (state == REQ && mem_req_ready) begin
                cnt <= '0;
            end else if (state == WAIT && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                owner <= OWN_NONE;
                if (owner == OWN_IFU) begin
                    ifu_rsp_valid <= 1'b1;
                    ifu_rdata     <= rsp_data;
                    ifu_rsp_err   <= rsp_err;
                end
                if (owner == OWN_LSU) begin
                    lsu_rsp_valid <= 1'b1;
                    lsu_rdata     <= rsp_data;
                    lsu_rsp_err   <= rsp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_mem_arb.sv
// Testbench for ysyx_23060096_mem_arb: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ysyx_23060096_mem_arb;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_rsp_err;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_rsp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        mem_rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ysyx_23060096_mem_arb #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr     (ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rdata    (ifu_rdata),
        .ifu_rsp_err  (ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr     (lsu_addr),
        .lsu_wen      (lsu_wen),
        .lsu_wdata    (lsu_wdata),
        .lsu_wmask    (lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rdata    (lsu_rdata),
        .lsu_rsp_err  (lsu_rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata),
        .mem_rsp_err  (mem_rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        mem_rsp_err   = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b need 0000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, busy});
        end
        checks++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 69'b0) begin
            errors++;
            $display("FAIL reset_mem got %h %b %h %h need 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        checks++;
        if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
             lsu_rsp_valid, lsu_rdata, lsu_rsp_err} !== 68'b0) begin
            errors++;
            $display("FAIL reset_rsp got %b %h %b %b %h %b need 0",
                     ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
                     lsu_rsp_valid, lsu_rdata, lsu_rsp_err);
        end
    endtask

    task automatic test_ifu_only();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ifu_grant got %b need 10",
                     {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, busy} !==
            {1'b1, 32'h8000_0000, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL ifu_req got v=%b a=%h w=%b m=%h b=%b",
                     mem_req_valid, mem_addr, mem_wen, mem_wmask, busy);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0010_0073;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_wait_valid got %b need 0", mem_req_valid);
        end
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err, lsu_rsp_valid, busy} !==
            {1'b1, 32'h0010_0073, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ifu_rsp got v=%b d=%h e=%b lv=%b b=%b",
                     ifu_rsp_valid, ifu_rdata, ifu_rsp_err, lsu_rsp_valid, busy);
        end
        tick();
        checks++;
        if (ifu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_pulse got %b need 0", ifu_rsp_valid);
        end
    endtask

    task automatic test_contention();
        bit el;
        do_reset();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr      = 32'h100;
        lsu_addr      = 32'h200;
        lsu_wen       = 1'b0;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            el = (i % 2) == 1;
            #1;
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== (el ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rr_grant%0d got %b need %b", i,
                         {ifu_req_ready, lsu_req_ready}, el ? 2'b01 : 2'b10);
            end
            tick();
            checks++;
            if ({ifu_req_ready, lsu_req_ready, mem_addr} !==
                {2'b00, el ? 32'h200 : 32'h100}) begin
                errors++;
                $display("FAIL rr_req%0d got rdy=%b a=%h", i,
                         {ifu_req_ready, lsu_req_ready}, mem_addr);
            end
            tick();
            mem_rsp_valid = 1'b1;
            mem_rdata     = i;
            #1;
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
                errors++;
                $display("FAIL rr_wait%0d got %b need 00", i,
                         {ifu_req_ready, lsu_req_ready});
            end
            tick();
            mem_rsp_valid = 1'b0;
            #1;
            checks++;
            if ({ifu_rsp_valid, lsu_rsp_valid} !== (el ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rr_rsp%0d got %b need %b", i,
                         {ifu_rsp_valid, lsu_rsp_valid}, el ? 2'b01 : 2'b10);
            end
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_grant got %b need 1", lsu_req_ready);
        end
        tick();
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                 busy, ifu_req_ready} !==
                {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall%0d got v=%b a=%h w=%b d=%h m=%h b=%b r=%b",
                         k, mem_req_valid, mem_addr, mem_wen, mem_wdata,
                         mem_wmask, busy, ifu_req_ready);
            end
            tick();
        end
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({lsu_rsp_valid, lsu_rdata, lsu_rsp_err, ifu_rsp_valid} !==
            {1'b1, 32'h1234, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL store_rsp got v=%b d=%h e=%b iv=%b",
                     lsu_rsp_valid, lsu_rdata, lsu_rsp_err, ifu_rsp_valid);
        end
    endtask

    task automatic test_timeout();
        int n;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_2000;
        mem_req_ready = 1'b1;
        tick();
        lsu_req_valid = 1'b0;
        tick();
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (lsu_rsp_valid === 1'b1) break;
        end
        checks++;
        if ({n, lsu_rdata, lsu_rsp_err} !== {32'd8, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL timeout got cycles=%0d d=%h e=%b need 8 0 1",
                     n, lsu_rdata, lsu_rsp_err);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h5555;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, busy, lsu_rdata} !== 35'b0) begin
            errors++;
            $display("FAIL stray_rsp got iv=%b lv=%b b=%b d=%h",
                     ifu_rsp_valid, lsu_rsp_valid, busy, lsu_rdata);
        end
    endtask

    task automatic test_err();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0004;
        mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rdata     = 32'hABCD_0000;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        #1;
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_err, ifu_rdata} !==
            {1'b1, 1'b1, 32'hABCD_0000}) begin
            errors++;
            $display("FAIL err_rsp got v=%b e=%b d=%h",
                     ifu_rsp_valid, ifu_rsp_err, ifu_rdata);
        end
        checks++;
        if ({lsu_rsp_valid, lsu_rsp_err, lsu_rdata} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL err_nonowner got v=%b e=%b d=%h need 0 1 0",
                     lsu_rsp_valid, lsu_rsp_err, lsu_rdata);
        end
    endtask

    task automatic test_reset_wait();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0010;
        mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        checks++;
        if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err, lsu_rsp_valid, lsu_rdata,
             lsu_rsp_err, mem_req_valid, mem_addr, mem_wen, mem_wdata,
             mem_wmask, busy} !== 139'b0) begin
            errors++;
            $display("FAIL rst_wait got iv=%b id=%h ie=%b lv=%b ld=%h le=%b mv=%b a=%h b=%b",
                     ifu_rsp_valid, ifu_rdata, ifu_rsp_err, lsu_rsp_valid,
                     lsu_rdata, lsu_rsp_err, mem_req_valid, mem_addr, busy);
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h77;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, busy} !== 3'b0) begin
            errors++;
            $display("FAIL rst_stray got %b need 000",
                     {ifu_rsp_valid, lsu_rsp_valid, busy});
        end
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0008;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_regrant got %b need 1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h13;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err} !== {1'b1, 32'h13, 1'b0}) begin
            errors++;
            $display("FAIL rst_refetch got v=%b d=%h e=%b",
                     ifu_rsp_valid, ifu_rdata, ifu_rsp_err);
        end
    endtask

    task automatic test_random();
        bit          m_busy, m_sent, m_pref_lsu, wi, wl;
        int          m_own, m_waited;
        logic [31:0] e_addr, e_wdata, e_ird, e_lrd;
        logic [3:0]  e_wmask;
        logic        e_wen, e_iv, e_ierr, e_lv, e_lerr;
        do_reset();
        m_busy = 0; m_sent = 0; m_pref_lsu = 0; m_own = 0; m_waited = 0;
        e_addr = 0; e_wdata = 0; e_ird = 0; e_lrd = 0; e_wmask = 0;
        e_wen = 0; e_iv = 0; e_ierr = 0; e_lv = 0; e_lerr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ifu_req_valid = ($urandom_range(0, 2) == 0);
            lsu_req_valid = ($urandom_range(0, 2) == 0);
            ifu_addr      = $urandom;
            lsu_addr      = $urandom;
            lsu_wen       = 1'($urandom_range(0, 1));
            lsu_wdata     = $urandom;
            lsu_wmask     = 4'($urandom_range(0, 15));
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = ($urandom_range(0, 3) == 0);
            mem_rdata     = $urandom;
            mem_rsp_err   = ($urandom_range(0, 4) == 0);
            #1;
            wi = !m_busy && ifu_req_valid && (!lsu_req_valid || !m_pref_lsu);
            wl = !m_busy && lsu_req_valid && !wi;
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== {wi, wl}) begin
                errors++;
                $display("FAIL rnd_ready c%0d got %b need %b", cyc,
                         {ifu_req_ready, lsu_req_ready}, {wi, wl});
            end
            checks++;
            if ({busy, mem_req_valid} !== {m_busy, m_busy && !m_sent}) begin
                errors++;
                $display("FAIL rnd_state c%0d got %b need %b", cyc,
                         {busy, mem_req_valid}, {m_busy, m_busy && !m_sent});
            end
            checks++;
            if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !==
                {e_addr, e_wen, e_wdata, e_wmask}) begin
                errors++;
                $display("FAIL rnd_mem c%0d got %h %b %h %h need %h %b %h %h",
                         cyc, mem_addr, mem_wen, mem_wdata, mem_wmask,
                         e_addr, e_wen, e_wdata, e_wmask);
            end
            checks++;
            if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err} !== {e_iv, e_ird, e_ierr}) begin
                errors++;
                $display("FAIL rnd_ifu c%0d got %b %h %b need %b %h %b", cyc,
                         ifu_rsp_valid, ifu_rdata, ifu_rsp_err, e_iv, e_ird, e_ierr);
            end
            checks++;
            if ({lsu_rsp_valid, lsu_rdata, lsu_rsp_err} !== {e_lv, e_lrd, e_lerr}) begin
                errors++;
                $display("FAIL rnd_lsu c%0d got %b %h %b need %b %h %b", cyc,
                         lsu_rsp_valid, lsu_rdata, lsu_rsp_err, e_lv, e_lrd, e_lerr);
            end
            e_iv = 0;
            e_lv = 0;
            if (wi || wl) begin
                m_busy     = 1;
                m_sent     = 0;
                m_own      = wl ? 2 : 1;
                m_pref_lsu = wi;
                e_addr     = wi ? ifu_addr : lsu_addr;
                e_wen      = wl && lsu_wen;
                e_wdata    = wl ? lsu_wdata : 32'h0;
                e_wmask    = wl ? lsu_wmask : 4'h0;
            end else if (m_busy && !m_sent) begin
                if (mem_req_ready) begin
                    m_sent   = 1;
                    m_waited = 0;
                end
            end else if (m_busy) begin
                m_waited++;
                if (mem_rsp_valid || m_waited == TMO) begin
                    m_busy = 0;
                    if (m_own == 1) begin
                        e_iv   = 1;
                        e_ird  = mem_rsp_valid ? mem_rdata : 32'h0;
                        e_ierr = mem_rsp_valid ? mem_rsp_err : 1'b1;
                    end else begin
                        e_lv   = 1;
                        e_lrd  = mem_rsp_valid ? mem_rdata : 32'h0;
                        e_lerr = mem_rsp_valid ? mem_rsp_err : 1'b1;
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ifu_only();
        test_contention();
        test_stall();
        test_timeout();
        test_err();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
